// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial off-chip link (transmitter now, receiver later).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_tx_baud_tick_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick_gen
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The tick must not depend on clear_i: the STOP tick itself decides whether a reload clears us.
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// 8N1 serial transmitter with a one-entry holding buffer and registered line output.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e               state_q;
  logic [DATA_BITS-1:0] buf_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_q;
  logic                 full_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 tick;
  logic                 accept;
  logic                 load;
  logic                 baud_clear;

  assign accept     = valid_i && !full_q;
  assign load       = full_q && ((state_q == IDLE) || ((state_q == STOP) && tick));
  assign baud_clear = (state_q == IDLE) || load;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear_i(baud_clear),
    .tick_o (tick)
  );

  // A reload empties the buffer; a same-edge handshake refills it, so the accept wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      if (load) begin
        full_q <= 1'b0;
      end
      if (accept) begin
        full_q <= 1'b1;
        buf_q  <= data_i;
      end
    end
  end

  // Line and busy are registered from the state, so both trail the state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tx_q   <= (state_q == START) ? 1'b0 : ((state_q == DATA) ? shift_q[0] : 1'b1);
      busy_q <= (state_q != IDLE);
      if (load) begin
        state_q <= START;
        shift_q <= buf_q;
        bit_q   <= '0;
      end else begin
        case (state_q)
          START: if (tick) state_q <= DATA;
          DATA: begin
            if (tick) begin
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
              if (bit_q == LAST_BIT) begin
                state_q <= STOP;
              end
            end
          end
          STOP: if (tick) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready_o = !full_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Randomised bench for serial_tx: frame-level reference model plus a sampling receiver.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data;
  logic       valid;
  int         sel;

  logic ready4, tx4, busy4;
  logic ready2, tx2, busy2;
  logic ready255, tx255, busy255;
  logic readySel, txSel, busySel;

  int cyc = 0;
  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] pending[$];
  logic [7:0] sentQ[$];
  logic [7:0] rxQ[$];
  int         accQ[$];
  int         startQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid && (sel == 0)),
    .ready_o(ready4), .tx_o(tx4), .busy_o(busy4)
  );
  serial_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid && (sel == 1)),
    .ready_o(ready2), .tx_o(tx2), .busy_o(busy2)
  );
  serial_tx #(.CLKS_PER_BIT(255)) dut255 (
    .clk(clk), .rst(rst), .data_i(data), .valid_i(valid && (sel == 2)),
    .ready_o(ready255), .tx_o(tx255), .busy_o(busy255)
  );

  assign readySel = (sel == 0) ? ready4 : ((sel == 1) ? ready2 : ready255);
  assign txSel    = (sel == 0) ? tx4    : ((sel == 1) ? tx2    : tx255);
  assign busySel  = (sel == 0) ? busy4  : ((sel == 1) ? busy2  : busy255);

  function automatic int cpbOf(input int which);
    return (which == 0) ? 4 : ((which == 1) ? 2 : 255);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame k occupies cycles [start_k, start_k+10N); start_k = max(accept_k+2, start_{k-1}+10N).
  task automatic applyStimulus(input string label, input int which, input int budget,
                               input int gapMax, input int abortOffset);
    int n, c, gap, lastStart, busyCnt, off, bitIdx, rxStart, s;
    logic expTx, expBusy, expReady, offering, rxActive, aborted;
    logic [7:0] rxByte, frameByte;
    n = cpbOf(which);
    sel = which;
    accQ.delete(); startQ.delete(); sentQ.delete(); rxQ.delete();
    lastStart = -100000;
    busyCnt = 0; offering = 1'b0; rxActive = 1'b0; aborted = 1'b0; rxStart = 0; rxByte = '0;
    gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      c = cyc;
      expTx = 1'b1; expBusy = 1'b0; expReady = 1'b1;
      for (int k = 0; k < startQ.size(); k++) begin
        if (c >= startQ[k] && c < startQ[k] + 10 * n) begin
          expBusy = 1'b1;
          bitIdx = (c - startQ[k]) / n;
          frameByte = sentQ[k];
          if (bitIdx == 0) expTx = 1'b0;
          else if (bitIdx <= 8) expTx = frameByte[bitIdx-1];
        end
        if (c >= accQ[k] && c < startQ[k] - 1) expReady = 1'b0;
      end
      checkOutput({label, ".tx"}, {31'b0, txSel}, {31'b0, expTx});
      checkOutput({label, ".busy"}, {31'b0, busySel}, {31'b0, expBusy});
      checkOutput({label, ".ready"}, {31'b0, readySel}, {31'b0, expReady});
      if (busySel === 1'b1) busyCnt++;

      if (!rxActive) begin
        if (txSel === 1'b0) begin
          rxActive = 1'b1;
          rxStart = c;
        end
      end else begin
        off = c - rxStart;
        if (off % n == n / 2) begin
          bitIdx = off / n;
          if (bitIdx >= 1 && bitIdx <= 8) begin
            rxByte[bitIdx-1] = txSel;
          end else if (bitIdx == 9) begin
            checkOutput({label, ".rxStop"}, {31'b0, txSel}, 32'd1);
            rxQ.push_back(rxByte);
            rxActive = 1'b0;
          end
        end
      end

      if (abortOffset >= 0 && !aborted && startQ.size() > 0 && c == startQ[0] + abortOffset) begin
        #2 rst = 1'b1;
        #1;
        checkOutput({label, ".asyncTx"}, {31'b0, txSel}, 32'd1);
        checkOutput({label, ".asyncBusy"}, {31'b0, busySel}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        accQ.delete(); startQ.delete(); sentQ.delete(); rxQ.delete(); pending.delete();
        offering = 1'b0; valid = 1'b0; data = 'x;
        busyCnt = 0; rxActive = 1'b0; aborted = 1'b1; lastStart = -100000;
        continue;
      end

      if (!offering && pending.size() > 0) begin
        if (gap > 0) gap--;
        else offering = 1'b1;
      end
      valid = offering;
      data  = offering ? pending[0] : 8'hxx;
      if (offering && readySel === 1'b1) begin
        s = (c + 3 > lastStart + 10 * n) ? c + 3 : lastStart + 10 * n;
        accQ.push_back(c + 1);
        startQ.push_back(s);
        lastStart = s;
        sentQ.push_back(pending.pop_front());
        offering = 1'b0;
        gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    data  = 'x;
    checkOutput({label, ".drained"}, pending.size(), 32'd0);
    if (abortOffset >= 0) checkOutput({label, ".aborted"}, {31'b0, aborted}, 32'd1);
    checkOutput({label, ".busyCycles"}, busyCnt, 10 * n * sentQ.size());
    checkOutput({label, ".rxCount"}, rxQ.size(), sentQ.size());
    for (int k = 0; k < rxQ.size() && k < sentQ.size(); k++) begin
      checkOutput({label, ".rxByte"}, {24'b0, rxQ[k]}, {24'b0, sentQ[k]});
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = 'x; sel = 0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset.tx", {31'b0, tx4}, 32'd1);
      checkOutput("reset.ready", {31'b0, ready4}, 32'd1);
      checkOutput("reset.busy", {31'b0, busy4}, 32'd0);
    end
    rst = 1'b0;
    applyStimulus("idle", 0, 20, 0, -1);
    pending = '{8'hA5};
    applyStimulus("single", 0, 60, 0, -1);
    pending = '{8'h00, 8'hFF};
    applyStimulus("b2b", 0, 100, 0, -1);
    pending = '{8'h0F};
    applyStimulus("abort0F", 0, 80, 0, 4 * 4 + 1);
    pending = '{8'hF0};
    applyStimulus("abortF0", 0, 80, 0, 4 * 4 + 1);
    pending = '{8'h3C};
    applyStimulus("cpb2", 1, 40, 0, -1);
    pending = '{8'h3C};
    applyStimulus("cpb255", 2, 2600, 0, -1);
    applyStimulus("xIdle", 0, 10, 0, -1);
    pending = '{8'h81};
    applyStimulus("hygiene", 0, 60, 0, -1);
    for (int w = 0; w < 2; w++) begin
      pending.delete();
      for (int j = 0; j < 6; j++) pending.push_back(8'($urandom));
      applyStimulus("random", w, 6 * (10 * cpbOf(w) + 32) + 40, 30, -1);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
